piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 83 ++++++++
 tb/tb_piso_serializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out feeder for the downstream SIPO: valid/ready load,
// MSB-first shift on clk2, a completion strobe one cycle after the last bit, and a wrapping word count.
module piso_serializer #(
    parameter int unsigned WIDTH    = 4,
    parameter logic        IDLE_BIT = 1'b0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk2,
    input  logic             in3,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last_bit,
    output logic             word_strobe,
    output logic [CNT_W-1:0] words_sent
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             accept;

    always_ff @(posedge clk2) begin
        if (in3) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            word_strobe <= 1'b0;
            words_sent  <= '0;
        end else begin
            state       <= state_nx;
            shreg       <= shreg_nx;
            cnt         <= cnt_nx;
            word_strobe <= last_bit;
            if (last_bit)
                words_sent <= words_sent + CNT_W'(1);
        end
    end

    // Ready on the last-bit cycle so a new word can follow with no gap.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        cnt_nx     = cnt;
        ser_valid  = 1'b0;
        ser_out    = IDLE_BIT;
        last_bit   = 1'b0;
        load_ready = 1'b0;
        accept     = 1'b0;

        case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid  = 1'b1;
                ser_out    = shreg[WIDTH-1];
                last_bit   = (cnt == LAST_CNT);
                load_ready = last_bit;
                shreg_nx   = {shreg[WIDTH-2:0], 1'b0};
                cnt_nx     = cnt + CW'(1);
                if (last_bit)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        accept = load_valid && load_ready;
        if (accept) begin
            state_nx = SHIFT;
            shreg_nx = par_in;
            cnt_nx   = '0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=4): serial stream, handshake, strobe,
// counter wrap (CNT_W=2 instance) and a reference 4-stage SIPO on the serial line.
module tb_piso_serializer;

    logic       clk2 = 1'b0;
    logic       in3;
    logic [3:0] par_in;
    logic       load_valid;
    logic       load_ready, ser_out, ser_valid, last_bit, word_strobe;
    logic [1:0] words_sent;
    logic       load_ready8, ser_out8, ser_valid8, last_bit8, word_strobe8;
    logic [7:0] words_sent8;

    int nvec = 0;
    int nmis = 0;
    int exp_ws = 0;
    int exp_ws8 = 0;

    // Reference SIPO: sipo[3]=out6 (farthest), sipo[0]=out3.
    logic [3:0] sipo = '0;

    always #5 clk2 = ~clk2;

    always @(posedge clk2) sipo <= {sipo[2:0], ser_out};

    piso_serializer #(.WIDTH(4), .IDLE_BIT(1'b0), .CNT_W(2)) u_dut (
        .clk2(clk2), .in3(in3), .par_in(par_in), .load_valid(load_valid),
        .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .last_bit(last_bit), .word_strobe(word_strobe), .words_sent(words_sent)
    );

    piso_serializer #(.WIDTH(4), .IDLE_BIT(1'b0), .CNT_W(8)) u_dut8 (
        .clk2(clk2), .in3(in3), .par_in(par_in), .load_valid(load_valid),
        .load_ready(load_ready8), .ser_out(ser_out8), .ser_valid(ser_valid8),
        .last_bit(last_bit8), .word_strobe(word_strobe8), .words_sent(words_sent8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
    endtask

    task automatic do_reset();
        in3 = 1'b1;
        load_valid = 1'b0;
        tick();
        in3 = 1'b0;
        exp_ws = 0;
        exp_ws8 = 0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ser_out"}, 32'(ser_out), 32'd0);
        chk({tag, ".ser_valid"}, 32'(ser_valid), 32'd0);
        chk({tag, ".last_bit"}, 32'(last_bit), 32'd0);
        chk({tag, ".load_ready"}, 32'(load_ready), 32'd1);
    endtask

    // Single word with idle gap after it; par_in is scrambled after the accept edge.
    task automatic send_word(input logic [3:0] w);
        par_in = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        par_in = ~w;
        for (int c = 1; c <= 4; c++) begin
            chk("sw.ser_out", 32'(ser_out), 32'(w[4-c]));
            chk("sw.ser_valid", 32'(ser_valid), 32'd1);
            chk("sw.last_bit", 32'(last_bit), 32'(c == 4));
            chk("sw.load_ready", 32'(load_ready), 32'(c == 4));
            chk("sw.strobe", 32'(word_strobe), 32'd0);
            tick();
        end
        exp_ws = (exp_ws + 1) % 4;
        exp_ws8 = (exp_ws8 + 1) % 256;
        chk("sw.strobe_hi", 32'(word_strobe), 32'd1);
        chk("sw.ser_valid_lo", 32'(ser_valid), 32'd0);
        chk("sw.words_sent", 32'(words_sent), 32'(exp_ws));
        chk("sw.words_sent8", 32'(words_sent8), 32'(exp_ws8));
        chk("sw.sipo", 32'(sipo), 32'(w));
        tick();
        chk("sw.strobe_lo", 32'(word_strobe), 32'd0);
    endtask

    // w1 accepted at edge k, w2 held valid from cycle k+1 and accepted at edge k+4.
    task automatic send_pair(input logic [3:0] w1, input logic [3:0] w2);
        logic [7:0] stream;
        stream = {w1, w2};
        par_in = w1;
        load_valid = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c <= 8) begin
                chk("bb.ser_out", 32'(ser_out), 32'(stream[8-c]));
                chk("bb.ser_valid", 32'(ser_valid), 32'd1);
                chk("bb.last_bit", 32'(last_bit), 32'(c == 4 || c == 8));
            end else begin
                chk("bb.ser_valid_lo", 32'(ser_valid), 32'd0);
                chk("bb.load_ready", 32'(load_ready), 32'd1);
            end
            if (c <= 4)
                chk("bb.ready_bp", 32'(load_ready), 32'(c == 4));
            chk("bb.strobe", 32'(word_strobe), 32'(c == 5 || c == 9));
            if (c == 5) chk("bb.sipo1", 32'(sipo), 32'(w1));
            if (c == 9) chk("bb.sipo2", 32'(sipo), 32'(w2));
            if (c == 1) par_in = w2;
            if (c == 5) load_valid = 1'b0;
            tick();
        end
        chk("bb.words_sent", 32'(words_sent), 32'd2);
        chk("bb.words_sent8", 32'(words_sent8), 32'd2);
    endtask

    initial begin
        in3 = 1'b0;
        par_in = '0;
        load_valid = 1'b0;
        #2;

        // Reset with load_valid also high: reset wins, nothing accepted.
        in3 = 1'b1;
        load_valid = 1'b1;
        par_in = 4'b1111;
        tick();
        in3 = 1'b0;
        load_valid = 1'b0;
        chk_idle("rst");
        chk("rst.strobe", 32'(word_strobe), 32'd0);
        chk("rst.words_sent", 32'(words_sent), 32'd0);

        // Idle hold for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle("idle");
            chk("idle.strobe", 32'(word_strobe), 32'd0);
        end

        // Single word 1011.
        do_reset();
        send_word(4'b1011);

        // Back-to-back gapless words, then backpressure case.
        do_reset();
        send_pair(4'b1100, 4'b0011);
        do_reset();
        send_pair(4'b0101, 4'b1111);

        // Reset mid-word during 1001.
        do_reset();
        par_in = 4'b1001;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("mid.bit3", 32'(ser_out), 32'd1);
        tick();
        chk("mid.bit2", 32'(ser_out), 32'd0);
        in3 = 1'b1;
        tick();
        in3 = 1'b0;
        chk_idle("mid");
        for (int i = 0; i < 6; i++) begin
            chk("mid.strobe", 32'(word_strobe), 32'd0);
            chk("mid.words_sent", 32'(words_sent), 32'd0);
            tick();
        end

        // Counter wrap on the CNT_W=2 instance: 1,2,3,0,1.
        do_reset();
        send_word(4'b0001);
        send_word(4'b1000);
        send_word(4'b0110);
        send_word(4'b1110);
        send_word(4'b0111);
        chk("wrap.final", 32'(words_sent), 32'd1);
        chk("wrap.final8", 32'(words_sent8), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
